// File: rtl/k2red_shift_pkg.sv
// Shared widths for the K^2-RED reduction pipeline.
package k2red_shift_pkg;
  localparam int A_W  = 128;  // product width from the 64x64 multiplier
  localparam int Q_W  = 64;   // modulus / result width
  localparam int SH_W = 7;    // shift-amount width for k1, k2, m
  localparam int R_W  = 130;  // signed intermediate width for R1/R2/R3
endpackage

// File: rtl/k2red_shift_if.sv
// Operand/config bundle and result for the K^2-RED pipeline.
interface k2red_shift_if;
  import k2red_shift_pkg::*;

  logic [A_W-1:0]  A;
  logic [Q_W-1:0]  Q;
  logic [SH_W-1:0] k1;
  logic [SH_W-1:0] k2;
  logic [SH_W-1:0] m;
  logic [Q_W-1:0]  C2;

  modport master (output A, Q, k1, k2, m, input C2);
  modport slave  (input A, Q, k1, k2, m, output C2);
endinterface

// File: rtl/k2red_shift_kred_step.sv
// One combinational K-RED step: y = k*(x mod 2^m) - (x >>> m), with k = 2^k1 - 2^k2.
module kred_step
  import k2red_shift_pkg::*;
(
  input  logic signed [R_W-1:0]  x_i,
  input  logic        [SH_W-1:0] k1_i,
  input  logic        [SH_W-1:0] k2_i,
  input  logic        [SH_W-1:0] m_i,
  output logic signed [R_W-1:0]  y_o
);

  logic        [R_W-1:0] mask;
  logic        [R_W-1:0] c0;
  logic signed [R_W-1:0] c1;

  always_comb begin
    mask = ~({R_W{1'b1}} << m_i);
    // Low digit is taken as an unsigned residue even when x is negative.
    c0   = x_i & mask;
    c1   = x_i >>> m_i;
    y_o  = $signed(c0 << k1_i) - $signed(c0 << k2_i) - c1;
  end

endmodule

// File: rtl/k2red_shift.sv
// Four-stage K^2-RED: two shift-only K-RED steps, then add-if-negative and
// subtract-if-too-large to land in [0, Q). Config travels with each operand.
module k2red_shift
  import k2red_shift_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  k2red_shift_if.slave bus
);

  function automatic logic signed [R_W-1:0] fix_neg(input logic signed [R_W-1:0] r,
                                                    input logic [Q_W-1:0] q);
    logic signed [R_W-1:0] qx;
    qx = $signed({{(R_W-Q_W){1'b0}}, q});
    return r[R_W-1] ? (r + qx) : r;
  endfunction

  function automatic logic [Q_W-1:0] fix_high(input logic signed [R_W-1:0] r,
                                              input logic [Q_W-1:0] q);
    logic [R_W-1:0] ru;
    logic [R_W-1:0] qx;
    logic [R_W-1:0] t;
    ru = r;
    qx = {{(R_W-Q_W){1'b0}}, q};
    t  = (ru >= qx) ? (ru - qx) : ru;
    return t[Q_W-1:0];
  endfunction

  logic signed [R_W-1:0]  a_ext;
  logic signed [R_W-1:0]  r1_p0_d, r1_p0_q;
  logic        [Q_W-1:0]  q_p0_q;
  logic        [SH_W-1:0] k1_p0_q, k2_p0_q, m_p0_q;
  logic signed [R_W-1:0]  r2_p1_d, r2_p1_q;
  logic        [Q_W-1:0]  q_p1_q;
  logic signed [R_W-1:0]  r3_p2_d, r3_p2_q;
  logic        [Q_W-1:0]  q_p2_q;
  logic        [Q_W-1:0]  c2_d, c2_q;

  assign a_ext = $signed({{(R_W-A_W){1'b0}}, bus.A});

  // S1: first K-RED on the raw product
  kred_step u_s1 (
    .x_i  (a_ext),
    .k1_i (bus.k1),
    .k2_i (bus.k2),
    .m_i  (bus.m),
    .y_o  (r1_p0_d)
  );

  // S2: second K-RED using the config captured alongside R1
  kred_step u_s2 (
    .x_i  (r1_p0_q),
    .k1_i (k1_p0_q),
    .k2_i (k2_p0_q),
    .m_i  (m_p0_q),
    .y_o  (r2_p1_d)
  );

  // S3/S4: R2 is in [-Q, 2Q), so one add and one subtract suffice
  always_comb begin
    r3_p2_d = fix_neg(r2_p1_q, q_p1_q);
    c2_d    = fix_high(r3_p2_q, q_p2_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_p0_q <= '0;
      q_p0_q  <= '0;
      k1_p0_q <= '0;
      k2_p0_q <= '0;
      m_p0_q  <= '0;
      r2_p1_q <= '0;
      q_p1_q  <= '0;
      r3_p2_q <= '0;
      q_p2_q  <= '0;
      c2_q    <= '0;
    end else begin
      r1_p0_q <= r1_p0_d;
      q_p0_q  <= bus.Q;
      k1_p0_q <= bus.k1;
      k2_p0_q <= bus.k2;
      m_p0_q  <= bus.m;
      r2_p1_q <= r2_p1_d;
      q_p1_q  <= q_p0_q;
      r3_p2_q <= r3_p2_d;
      q_p2_q  <= q_p1_q;
      c2_q    <= c2_d;
    end
  end

  assign bus.C2 = c2_q;

endmodule

// File: tb/tb_k2red_shift.sv
// Directed and streaming checks of k2red_shift against an independent big-int model.
module tb_k2red_shift;
  import k2red_shift_pkg::*;

  localparam logic [63:0] QA  = 64'd9223336852482686977;
  localparam logic [6:0]  K1A = 7'd18;
  localparam logic [6:0]  K2A = 7'd0;
  localparam logic [6:0]  MA  = 7'd45;
  localparam logic [63:0] QB  = 64'd3221225473;  // 3*2^30 + 1
  localparam logic [6:0]  K1B = 7'd2;
  localparam logic [6:0]  K2B = 7'd0;
  localparam logic [6:0]  MB  = 7'd30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  k2red_shift_if bus ();
  k2red_shift dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_h [4];
  bit          vld_h [4];
  string       tag_h [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [127:0] a, input logic [63:0] q,
                                        input logic [6:0] k1, input logic [6:0] k2);
    logic [255:0] kk;
    logic [255:0] p;
    kk = (256'd1 << k1) - (256'd1 << k2);
    p  = (kk * kk * {128'd0, a}) % {192'd0, q};
    return p[63:0];
  endfunction

  function automatic logic [127:0] rnd_a(input logic [63:0] q);
    logic [255:0] r;
    logic [255:0] qq;
    r  = {128'd0, $urandom, $urandom, $urandom, $urandom};
    qq = {192'd0, q} * {192'd0, q};
    r  = r % qq;
    return r[127:0];
  endfunction

  // After reset every stage holds zero, which the datapath maps to C2 = 0.
  task automatic clear_hist();
    for (int i = 0; i < 4; i++) begin
      exp_h[i] = '0;
      vld_h[i] = 1'b1;
      tag_h[i] = "post_rst";
    end
  endtask

  task automatic cyc(input string tag, input logic [127:0] a, input logic [63:0] q,
                     input logic [6:0] k1, input logic [6:0] k2, input logic [6:0] m);
    bus.A  = a;
    bus.Q  = q;
    bus.k1 = k1;
    bus.k2 = k2;
    bus.m  = m;
    @(posedge clk);
    for (int i = 3; i > 0; i--) begin
      exp_h[i] = exp_h[i-1];
      vld_h[i] = vld_h[i-1];
      tag_h[i] = tag_h[i-1];
    end
    exp_h[0] = model(a, q, k1, k2);
    vld_h[0] = 1'b1;
    tag_h[0] = tag;
    #1;
    if (vld_h[3]) chk(tag_h[3], bus.C2, exp_h[3]);
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      if (($urandom & 1) == 0) cyc("burst_a", rnd_a(QA), QA, K1A, K2A, MA);
      else                     cyc("burst_b", rnd_a(QB), QB, K1B, K2B, MB);
    end
  endtask

  initial begin
    logic [127:0] q5;
    rst    = 1'b1;
    bus.A  = {$urandom, $urandom, $urandom, $urandom};
    bus.Q  = QA;
    bus.k1 = K1A;
    bus.k2 = K2A;
    bus.m  = MA;
    #2;
    chk("rst_init", bus.C2, 64'd0);
    for (int i = 0; i < 2; i++) begin
      bus.A = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      chk("rst_hold", bus.C2, 64'd0);
    end
    rst = 1'b0;
    clear_hist();

    q5 = {64'd0, QA} * 128'd5;
    cyc("zero",   128'd0, QA, K1A, K2A, MA);
    cyc("golden", 128'd15503864686927983900306131265744894665, QA, K1A, K2A, MA);
    cyc("one",    128'd1, QA, K1A, K2A, MA);
    cyc("two45",  128'd1 << 45, QA, K1A, K2A, MA);
    cyc("eq_q",   {64'd0, QA}, QA, K1A, K2A, MA);
    cyc("q_x5",   q5, QA, K1A, K2A, MA);
    for (int i = 0; i < 4; i++) cyc("flush", 128'd0, QA, K1A, K2A, MA);

    // Hand-computed expectations, independent of the model.
    chk("model_golden", model(128'd15503864686927983900306131265744894665, QA, K1A, K2A),
        64'd8123906769876496122);
    chk("model_two45", model(128'd1 << 45, QA, K1A, K2A), 64'd9223336852482424834);

    burst(24);

    #1;
    rst = 1'b1;
    #1;
    chk("rst_async", bus.C2, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_mid_hold", bus.C2, 64'd0);
    rst = 1'b0;
    clear_hist();

    cyc("post_one", 128'd1, QA, K1A, K2A, MA);
    burst(16);
    for (int i = 0; i < 4; i++) cyc("flush2", 128'd0, QA, K1A, K2A, MA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
